// File: rtl/wb_regfile.sv
// wb_regfile: write-back latch plus 32x32 register file with two forwarding read ports.
// Ports: clk/rst_n, stall/flush, w_reg_*_in from execute, r1/r2 read ports, wb_reg_*_out latch.
module wb_regfile #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_NUM        = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
    input  logic [REG_DATA_WIDTH-1:0] w_reg_data_in,
    input  logic                      w_reg_en_in,
    input  logic                      r1_en,
    input  logic [REG_ADDR_WIDTH-1:0] r1_addr,
    input  logic                      r2_en,
    input  logic [REG_ADDR_WIDTH-1:0] r2_addr,
    output logic [REG_DATA_WIDTH-1:0] r1_data,
    output logic [REG_DATA_WIDTH-1:0] r2_data,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_addr_out,
    output logic [REG_DATA_WIDTH-1:0] wb_reg_data_out,
    output logic                      wb_reg_en_out
);

    logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [REG_DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                      wb_en_q, wb_en_d;
    logic [REG_DATA_WIDTH-1:0] regs_q [REG_NUM];

    // Flush only kills the enable; address/data are don't-care once invalid.
    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_en_d   = wb_en_q;
        if (flush) begin
            wb_en_d = 1'b0;
        end else if (!stall) begin
            wb_addr_d = w_reg_addr_in;
            wb_data_d = w_reg_data_in;
            wb_en_d   = w_reg_en_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
        end else begin
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
        end
    end

    // Commit ignores stall: a held entry rewrites the same value, which is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_q && (wb_addr_q != '0)) begin
            regs_q[wb_addr_q] <= wb_data_q;
        end
    end

    // Newest producer wins: execute result, then latched write-back, then array.
    function automatic logic [REG_DATA_WIDTH-1:0] rd_sel(
        input logic                      en,
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic [REG_DATA_WIDTH-1:0] arr
    );
        logic [REG_DATA_WIDTH-1:0] v;
        v = arr;
        if (!en || (addr == '0)) begin
            v = '0;
        end else if (w_reg_en_in && (w_reg_addr_in == addr)) begin
            v = w_reg_data_in;
        end else if (wb_en_q && (wb_addr_q == addr)) begin
            v = wb_data_q;
        end
        return v;
    endfunction

    always_comb begin
        r1_data = rd_sel(r1_en, r1_addr, regs_q[r1_addr]);
    end

    always_comb begin
        r2_data = rd_sel(r2_en, r2_addr, regs_q[r2_addr]);
    end

    assign wb_reg_addr_out = wb_addr_q;
    assign wb_reg_data_out = wb_data_q;
    assign wb_reg_en_out   = wb_en_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a reference model.
// Model: architectural register array plus one pending write-back slot.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic [4:0]  w_reg_addr_in;
    logic [31:0] w_reg_data_in;
    logic        w_reg_en_in;
    logic        r1_en, r2_en;
    logic [4:0]  r1_addr, r2_addr;
    logic [31:0] r1_data, r2_data;
    logic [4:0]  wb_reg_addr_out;
    logic [31:0] wb_reg_data_out;
    logic        wb_reg_en_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [4:0]  m_wb_addr;
    logic [31:0] m_wb_data;
    logic        m_wb_en;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .w_reg_addr_in   (w_reg_addr_in),
        .w_reg_data_in   (w_reg_data_in),
        .w_reg_en_in     (w_reg_en_in),
        .r1_en           (r1_en),
        .r1_addr         (r1_addr),
        .r2_en           (r2_en),
        .r2_addr         (r2_addr),
        .r1_data         (r1_data),
        .r2_data         (r2_data),
        .wb_reg_addr_out (wb_reg_addr_out),
        .wb_reg_data_out (wb_reg_data_out),
        .wb_reg_en_out   (wb_reg_en_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_wb_addr = '0;
        m_wb_data = '0;
        m_wb_en   = 1'b0;
    endfunction

    // A register read sees the most recent value produced for it.
    function automatic logic [31:0] model_read(input logic en,
                                               input logic [4:0] a);
        if (!en || a == 0) return '0;
        if (w_reg_en_in && w_reg_addr_in == a) return w_reg_data_in;
        if (m_wb_en && m_wb_addr == a) return m_wb_data;
        return m_regs[a];
    endfunction

    function automatic void model_clock();
        if (m_wb_en && m_wb_addr != 0) m_regs[m_wb_addr] = m_wb_data;
        if (flush) begin
            m_wb_en = 1'b0;
        end else if (!stall) begin
            m_wb_addr = w_reg_addr_in;
            m_wb_data = w_reg_data_in;
            m_wb_en   = w_reg_en_in;
        end
    endfunction

    task automatic drive(input logic st, input logic fl,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic we,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        stall = st; flush = fl;
        w_reg_addr_in = wa; w_reg_data_in = wd; w_reg_en_in = we;
        r1_en = e1; r1_addr = a1; r2_en = e2; r2_addr = a2;
    endtask

    // Inputs are applied at negedge; compare mid-cycle, then advance a clock.
    task automatic step(input string tag);
        #1;
        check({tag, ".r1"}, r1_data, model_read(r1_en, r1_addr));
        check({tag, ".r2"}, r2_data, model_read(r2_en, r2_addr));
        check({tag, ".wb_en"}, {31'b0, wb_reg_en_out}, {31'b0, m_wb_en});
        check({tag, ".wb_addr"}, {27'b0, wb_reg_addr_out}, {27'b0, m_wb_addr});
        check({tag, ".wb_data"}, wb_reg_data_out, m_wb_data);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.wb_en", {31'b0, wb_reg_en_out}, 32'd0);
        check("reset.wb_data", wb_reg_data_out, 32'd0);
        rst_n = 1'b1;

        // Basic write then read through EX forward, WB forward, array.
        drive(0, 0, 3, 32'hDEADBEEF, 1, 1, 3, 1, 3);
        step("basic.ex");
        drive(0, 0, 0, 0, 0, 1, 3, 1, 3);
        step("basic.wb");
        step("basic.arr");
        check("basic.r2_const", r2_data, 32'hDEADBEEF);

        // Read-enable gating.
        drive(0, 0, 0, 0, 0, 0, 3, 1, 3);
        step("gate");

        // Execute value beats the write-back latch for the same index.
        drive(0, 0, 7, 32'h11, 1, 1, 7, 1, 7);
        step("fwd.a");
        drive(0, 0, 7, 32'h22, 1, 1, 7, 1, 7);
        step("fwd.b");
        drive(0, 0, 0, 0, 0, 1, 7, 1, 7);
        step("fwd.c");
        step("fwd.d");

        // Index 0 is never writable or forwarded.
        drive(0, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 1, 0);
        step("zero.ex");
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("zero.wb");
        step("zero.arr");

        // Stall holds the latch, flush kills it even under stall.
        drive(0, 0, 9, 32'hA5, 1, 1, 9, 1, 10);
        step("st.load");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 10, 32'h5A, 1, 1, 9, 0, 10);
            step("st.hold");
        end
        drive(1, 1, 10, 32'h5A, 1, 1, 9, 1, 9);
        step("st.flush");
        drive(0, 0, 0, 0, 0, 1, 10, 1, 9);
        step("st.after");
        step("st.after2");

        // Mid-stream reset drops everything, including a pending write.
        drive(0, 0, 5, 32'h1234, 1, 1, 5, 1, 5);
        step("rst.wr");
        drive(0, 0, 0, 0, 0, 1, 5, 1, 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.wb_en_now", {31'b0, wb_reg_en_out}, 32'd0);
        rst_n = 1'b1;
        step("rst.read");
        check("rst.r5_zero", r1_data, 32'd0);

        // Randomized traffic over a narrow index range for frequent collisions.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0,
                  5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 7) != 0,
                  5'($urandom_range(0, 7)));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the execute-stage write-back interface: accepts w_reg_addr/w_reg_data/w_reg_en, registers them in a MEM/WB-style latch, and commits them into a 32x32 general-purpose register file.
- Supplies the two decode-stage read ports, with forwarding from both the in-flight execute result and the latched write-back entry.
- Register 0 is hardwired to zero.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- REG_DATA_WIDTH, 32, register data width.
- REG_NUM, 32, number of registers (must equal 2**REG_ADDR_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold the write-back latch contents.
- flush  input  1  invalidate the write-back latch entry.
- w_reg_addr_in  input  REG_ADDR_WIDTH  destination index from execute.
- w_reg_data_in  input  REG_DATA_WIDTH  result data from execute.
- w_reg_en_in  input  1  execute result writes a register.
- r1_en  input  1  read port 1 enable.
- r1_addr  input  REG_ADDR_WIDTH  read port 1 index.
- r2_en  input  1  read port 2 enable.
- r2_addr  input  REG_ADDR_WIDTH  read port 2 index.
- r1_data  output  REG_DATA_WIDTH  read port 1 data (combinational).
- r2_data  output  REG_DATA_WIDTH  read port 2 data (combinational).
- wb_reg_addr_out  output  REG_ADDR_WIDTH  latched write-back index.
- wb_reg_data_out  output  REG_DATA_WIDTH  latched write-back data.
- wb_reg_en_out  output  1  latched write-back enable.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously clears wb_reg_addr_out, wb_reg_data_out and wb_reg_en_out to 0, and all REG_NUM array entries to 0.
  - Reset mid-operation drops any pending write.
- Write-back latch, updated on posedge clk:
  - flush=1: wb_reg_en_out<=0; addr and data hold. Flush has priority over stall.
  - else stall=1: all three latch outputs hold.
  - else: latch <= {w_reg_addr_in, w_reg_data_in, w_reg_en_in}.
- Array commit, on posedge clk:
  - When wb_reg_en_out=1 and wb_reg_addr_out!=0: array[wb_reg_addr_out] <= wb_reg_data_out.
  - The commit is independent of stall; repeating the same write during a stall is idempotent and permitted.
  - Writes to index 0 are discarded.
- Latency:
  - Execute result appears on wb_* outputs 1 cycle later.
  - It is present in the array 2 cycles after being driven.
- Read ports: combinational and identical for ports 1 and 2. Priority, highest first:
  1. rN_en=0 -> 0.
  2. rN_addr=0 -> 0.
  3. w_reg_en_in=1 and w_reg_addr_in==rN_addr -> w_reg_data_in (execute forward).
  4. wb_reg_en_out=1 and wb_reg_addr_out==rN_addr -> wb_reg_data_out (write-back forward).
  5. Otherwise -> array[rN_addr].
- Simultaneous events:
  - When execute and write-back target the same index, the execute value wins on reads (newest).
  - Both ports may read the same index in the same cycle.
  - A read of an index being committed this edge returns the forwarded value before the edge and the array value after it; these are identical.
- No read is registered, so there is no read latency and no read-port handshake.

Test Plan:
- Reset: assert rst_n=0 mid-stream after writing r5=0x1234 -> wb_reg_en_out=0 immediately; after release, r1_addr=5, r1_en=1 returns 0x00000000.
- Basic write/read: drive addr=3, data=0xDEADBEEF, en=1 for one cycle, then en=0 -> wb_* outputs show 3/0xDEADBEEF the next cycle; r2 reading 3 returns 0xDEADBEEF in all three cycles (EX forward, WB forward, array); after 2 cycles the array holds 0xDEADBEEF.
- Forward priority: the WB latch holds r7=0x11 while execute drives r7=0x22 -> r1_data=0x22 and r2_data=0x22 on the same read of 7; next cycle returns 0x22.
- Zero register: write addr=0, data=0xFFFFFFFF, en=1 -> reads of index 0 return 0 in every cycle, including the forward cycle; array[0] stays 0.
- Stall/flush: latch r9=0xA5 with stall=1 for 3 cycles while execute changes to r10=0x5A -> wb_* hold 9/0xA5. Then flush=1 with stall=1 -> wb_reg_en_out=0 next cycle, array[10] unchanged (0).
- Read enable gating: r1_en=0 with r1_addr=3 holding 0xDEADBEEF -> r1_data=0 while r2_en=1 on the same address returns 0xDEADBEEF.
